// File: rtl/regfile_alu_sequencer_if.sv
// Bus between the ALU sequencer and its environment: instruction stream, register-file ports, retire stream.
// The master modport is the sequencer; slave is the producer/register-file side.
interface regfile_alu_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [ADDR_W-1:0] rf_addr_a;
  logic [ADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [ADDR_W-1:0] rf_addr_wr;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_we;
  logic              res_valid;
  logic [ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0] res_data;
  logic              busy;

  modport master (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rf_data_a, rf_data_b,
    output in_ready, rf_addr_a, rf_addr_b, rf_addr_wr, rf_data_in, rf_we,
           res_valid, res_rd, res_data, busy
  );

  modport slave (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rf_data_a, rf_data_b,
    input  in_ready, rf_addr_a, rf_addr_b, rf_addr_wr, rf_data_in, rf_we,
           res_valid, res_rd, res_data, busy
  );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// Three-stage (issue/execute/writeback) ALU sequencer driving a 2R1W register file.
// Define RFSEQ_FORWARD_EN for operand forwarding; otherwise hazards stall in_ready.
module regfile_alu_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  regfile_alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LI   = 3'd5,
    OP_ADDI = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  op_e               in_op;
  logic              use_a, use_b, accept;
  logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

  logic              ex_valid_q;
  op_e               ex_op_q;
  logic [ADDR_W-1:0] ex_rd_q;
  logic [DATA_W-1:0] ex_imm_q;

  logic              wb_valid_q, wb_valid_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] opa, opb, result;

  assign bus.rf_addr_a = bus.in_rs1;
  assign bus.rf_addr_b = bus.in_rs2;

  // Only sources the opcode actually reads, and never r0, can create a hazard.
  always_comb begin
    in_op    = op_e'(bus.in_op);
    use_a    = (in_op != OP_LI);
    use_b    = (in_op != OP_LI) && (in_op != OP_ADDI);
    ex_hit_a = use_a && (bus.in_rs1 != '0) && ex_valid_q && (bus.in_rs1 == ex_rd_q);
    ex_hit_b = use_b && (bus.in_rs2 != '0) && ex_valid_q && (bus.in_rs2 == ex_rd_q);
    wb_hit_a = use_a && (bus.in_rs1 != '0) && wb_valid_q && (bus.in_rs1 == wb_rd_q);
    wb_hit_b = use_b && (bus.in_rs2 != '0) && wb_valid_q && (bus.in_rs2 == wb_rd_q);
  end

  assign accept = bus.in_valid && bus.in_ready;

`ifdef RFSEQ_FORWARD_EN
  typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_LAST} fwd_e;

  fwd_e              fwd_a_d, fwd_b_d, ex_fwd_a_q, ex_fwd_b_q;
  logic [DATA_W-1:0] last_q;

  assign bus.in_ready = 1'b1;

  // EX producer is newer than WB producer, so it takes priority.
  always_comb begin
    fwd_a_d = ex_hit_a ? FWD_WB : (wb_hit_a ? FWD_LAST : FWD_RF);
    fwd_b_d = ex_hit_b ? FWD_WB : (wb_hit_b ? FWD_LAST : FWD_RF);
  end

  always_comb begin
    case (ex_fwd_a_q)
      FWD_WB:   opa = wb_data_q;
      FWD_LAST: opa = last_q;
      default:  opa = bus.rf_data_a;
    endcase
    case (ex_fwd_b_q)
      FWD_WB:   opb = wb_data_q;
      FWD_LAST: opb = last_q;
      default:  opb = bus.rf_data_b;
    endcase
  end

  // last_q holds what WB was writing on the previous edge, i.e. the value the file read missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_fwd_a_q <= FWD_RF;
      ex_fwd_b_q <= FWD_RF;
      last_q     <= '0;
    end else begin
      if (accept) begin
        ex_fwd_a_q <= fwd_a_d;
        ex_fwd_b_q <= fwd_b_d;
      end
      last_q <= wb_data_q;
    end
  end
`else
  assign bus.in_ready = !(ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b);
  assign opa          = bus.rf_data_a;
  assign opb          = bus.rf_data_b;
`endif

  always_comb begin
    result = '0;
    case (ex_op_q)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_LI:   result = ex_imm_q;
      OP_ADDI: result = opa + ex_imm_q;
      OP_SLTU: result[0] = (opa < opb);
    endcase
  end

  always_comb begin
    wb_valid_d = ex_valid_q;
    rf_we_d    = ex_valid_q && (ex_rd_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_ADD;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
      wb_valid_q <= 1'b0;
      rf_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q  <= in_op;
        ex_rd_q  <= bus.in_rd;
        ex_imm_q <= bus.in_imm;
      end
      wb_valid_q <= wb_valid_d;
      rf_we_q    <= rf_we_d;
      if (ex_valid_q) begin
        wb_rd_q   <= ex_rd_q;
        wb_data_q <= result;
      end
    end
  end

  assign bus.rf_addr_wr = wb_rd_q;
  assign bus.rf_data_in = wb_data_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.res_valid  = wb_valid_q;
  assign bus.res_rd     = wb_rd_q;
  assign bus.res_data   = wb_data_q;
  assign bus.busy       = ex_valid_q || wb_valid_q;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Scoreboard bench for regfile_alu_sequencer with a behavioural register file and architectural model.
module tb_regfile_alu_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
`ifdef RFSEQ_FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 2;
`endif

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_alu_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  exp_t        q[$];

  logic [DW-1:0] mem        [256] = '{default: '0};
  logic [DW-1:0] model      [256] = '{default: '0};
  logic [DW-1:0] model_save [256];

  always @(posedge clk) cyc <= cyc + 1;

  // External 2R1W register file: registered reads, r0 hardwired to zero.
  always @(posedge clk) begin
    bus.rf_data_a <= (bus.rf_addr_a == '0) ? '0 : mem[bus.rf_addr_a];
    bus.rf_data_b <= (bus.rf_addr_b == '0) ? '0 : mem[bus.rf_addr_b];
    if (bus.rf_we && bus.rf_addr_wr != '0) mem[bus.rf_addr_wr] <= bus.rf_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] imm);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return imm;
      3'd6:    return a + imm;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 15) == 0) return 8'(248 + $urandom_range(0, 7));
    return 8'($urandom_range(0, 7));
  endfunction

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] imm, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    #1;
    while (!bus.in_ready) begin
      @(negedge clk);
      #1;
      waits++;
      if (waits > 8) begin
        chk("in_ready_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    e.rd   = rd;
    e.data = ref_alu(op, model[rs1], model[rs2], imm);
    e.cyc  = cyc + 2;
    q.push_back(e);
    if (rd != '0) model[rd] = e.data;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      chk("busy", bus.busy, q.size() != 0);
      if (bus.res_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", bus.res_valid, 0);
        end else begin
          e = q.pop_front();
          chk("res_rd", bus.res_rd, e.rd);
          chk("res_data", bus.res_data, e.data);
          chk("rf_we", bus.rf_we, e.rd != '0);
          chk("rf_addr_wr", bus.rf_addr_wr, e.rd);
          chk("rf_data_in", bus.rf_data_in, e.data);
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("rf_we_idle", bus.rf_we, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd5;
    bus.in_rd    = 8'd1;
    bus.in_imm   = 32'hDEAD;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_addr_wr", bus.rf_addr_wr, 0);
    chk("rst_rf_data_in", bus.rf_data_in, 0);
    chk("rst_res_rd", bus.res_rd, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b0;

    issue(3'd5, 8'd1, 8'd0, 8'd0, 32'd5, w);
    idle(3);

    issue(3'd5, 8'd1, 8'd0, 8'd0, 32'd7, w);
    issue(3'd6, 8'd2, 8'd1, 8'd0, 32'd3, w);
    chk("stall_addi", w, EXP_STALL);
    issue(3'd0, 8'd3, 8'd2, 8'd1, 32'd0, w);
    chk("stall_add", w, EXP_STALL);
    idle(3);

    issue(3'd5, 8'd5, 8'd0, 8'd0, 32'd1, w);
    issue(3'd5, 8'd6, 8'd0, 8'd0, 32'd2, w);
    issue(3'd0, 8'd7, 8'd5, 8'd6, 32'd0, w);
    chk("stall_dist2", w, EXP_STALL);
    idle(3);

    issue(3'd5, 8'd0, 8'd0, 8'd0, 32'd9, w);
    issue(3'd0, 8'd4, 8'd0, 8'd0, 32'd0, w);
    chk("stall_r0", w, 0);
    idle(3);

    issue(3'd5, 8'd1, 8'd0, 8'd0, 32'd0, w);
    issue(3'd5, 8'd2, 8'd0, 8'd0, 32'd1, w);
    issue(3'd1, 8'd3, 8'd1, 8'd2, 32'd0, w);
    issue(3'd7, 8'd4, 8'd1, 8'd2, 32'd0, w);
    issue(3'd7, 8'd4, 8'd3, 8'd2, 32'd0, w);
    issue(3'd6, 8'd5, 8'd3, 8'd0, 32'd1, w);
    chk("model_sub", model[3], 32'hFFFF_FFFF);
    chk("model_addi_wrap", model[5], 0);
    idle(3);

    issue(3'd5, 8'd10, 8'd0, 8'd0, 32'h100, w);
    issue(3'd5, 8'd11, 8'd0, 8'd0, 32'h200, w);
    idle(4);
    for (int i = 0; i < 256; i++) model_save[i] = model[i];
    issue(3'd5, 8'd10, 8'd0, 8'd0, 32'h55, w);
    issue(3'd5, 8'd11, 8'd0, 8'd0, 32'h66, w);
    #2;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_rf_we", bus.rf_we, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    q.delete();
    for (int i = 0; i < 256; i++) model[i] = model_save[i];
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midrst_hold_rf_we", bus.rf_we, 0);
      chk("midrst_hold_res_valid", bus.res_valid, 0);
      chk("midrst_hold_busy", bus.busy, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 8'd12, 8'd10, 8'd11, 32'd0, w);
    idle(3);
    chk("model_after_rst", model[12], 32'h300);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(3'($urandom_range(0, 7)), pick(), pick(), pick(), $urandom, w);
    end
    idle(1);

    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_alu_sequencer.md
# regfile_alu_sequencer

- Initiator side of the three-port register file (two synchronous read ports, one write port, register 0 hardwired to zero).
- Accepts a stream of register-to-register ALU instructions over a valid/ready handshake and drives the file's read addresses.
- Computes on the returned operands, then drives the write port with the result.
- Three-stage in-order pipeline (issue, execute, writeback); an observable retire stream is provided for checking.

## Interface
- `DATA_W`, 32, operand/result width; must match the register file.
- `ADDR_W`, 8, register index width; must match the register file.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  instruction accepted on an edge where `in_valid && in_ready`.
- `in_op`  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LI, 6 ADDI, 7 SLTU.
- `in_rd`, `in_rs1`, `in_rs2`  in  ADDR_W  destination and sources.
- `in_imm`  in  DATA_W  immediate for LI/ADDI.
- `rf_addr_a`, `rf_addr_b`  out  ADDR_W  read addresses. Combinational copies of `in_rs1`/`in_rs2`, always driven, regardless of valid.
- `rf_data_a`, `rf_data_b`  in  DATA_W  registered read data, valid the cycle after the address edge.
- `rf_addr_wr`, `rf_data_in`  out  ADDR_W/DATA_W  write address/data, registered.
- `rf_we`  out  1  write enable, registered.
- `res_valid`  out  1  one-cycle retire pulse.
- `res_rd`, `res_data`  out  ADDR_W/DATA_W  retired destination and result.
- `busy`  out  1  EX or WB stage holds a valid instruction.

## Operation
**Issue.** On an accept edge T, the register file samples `rf_addr_a`/`rf_addr_b`. The instruction (op, rd, imm, source tags) moves into EX.

**Execute (cycle after T).** Form operands from `rf_data_a`/`rf_data_b` or a forwarded value, then compute:
- ADD, SUB, AND, OR, XOR: rs1 op rs2; modulo 2^DATA_W, no flags.
- LI: imm.
- ADDI: rs1 + imm.
- SLTU: unsigned rs1 < rs2 → 1, else 0.

**Writeback (registered at T+1).** Registered values:
- `res_valid=1`, `res_rd=rd`, `res_data=result`.
- `rf_addr_wr=rd`, `rf_data_in=result`, `rf_we=(rd!=0)`.
- The register file commits at edge T+2.

**rd = 0.** The instruction retires normally (`res_valid`, `res_data`=computed result), `rf_we` stays 0, and it is never a forwarding source.

**Operand use.** LI uses no sources, ADDI uses rs1 only; all others use both. Hazard and forwarding checks apply to used, nonzero sources only.

**Hazards** (read is stale unless handled):
- Source equals rd of the instruction in EX at accept (result not yet written).
- Source equals rd of the instruction in WB at accept (write and read on the same edge return old data).

Forwarding is selected at accept and stored with the instruction:
- Match against EX → use the WB-register result during execute.
- Match against WB → use a one-deep "last written" register.
- Newer match wins.

**`busy`** = EX.valid | WB.valid.

**Reset.**
- All stage valids clear.
- `rf_we`=0, `rf_addr_wr`=0, `rf_data_in`=0, `res_valid`=0, `res_rd`=0, `res_data`=0, `busy`=0.
- `in_ready` is 1 during and after reset; no accept occurs while `rst` is high.
- Asserting `rst` mid-operation drops in-flight instructions immediately; no further `rf_we` or `res_valid` is produced for them.

## Timing
- Latency: accept edge T → `res_valid`/`rf_we` high for the cycle after edge T+1 → register file updated at edge T+2.
- Throughput with forwarding: one instruction per cycle, `in_ready` constantly 1.
- No backpressure on the retire stream or the write port.
- `in_ready` is combinational from `in_valid`, `in_op`, the source fields and the stage state (no-forwarding build only). No other combinational input-to-output paths exist besides `rf_addr_a`/`rf_addr_b`.

## Configuration
- `RFSEQ_FORWARD_EN` defined: forwarding as above; `in_ready` = 1.
- Undefined: no forwarding logic. `in_ready` = 0 while any used nonzero source matches a valid nonzero rd in EX or WB. The stall is at most 2 cycles per dependency, and the offered instruction and `rf_addr_a`/`rf_addr_b` are held by the producer. Results are identical to the forwarding build; only the cycle count differs.

## Test plan
- Reset, then LI r1,5 accepted at edge T → `res_valid`, `res_rd`=1, `res_data`=5, `rf_we`=1, `rf_addr_wr`=1 in the cycle after T+1; all outputs 0 while `rst` is high.
- Back-to-back LI r1,7; ADDI r2,r1,3; ADD r3,r2,r1 on consecutive cycles → retire 7, 10, 17 in consecutive cycles. Without `RFSEQ_FORWARD_EN`: same values, `in_ready` low 2 cycles before each dependent instruction.
- Distance-2 hazard: LI r5,1; LI r6,2; ADD r7,r5,r6 on consecutive cycles → r7 result 3 (exercises the same-edge write/read path).
- r0 handling: LI r0,9 → `res_data`=9, `rf_we`=0. Then ADD r4,r0,r0 → 0, with no forwarding from the r0 write.
- Arithmetic edges: r1=0, r2=1. SUB r3,r1,r2 → 0xFFFFFFFF; SLTU r4,r1,r2 → 1; SLTU r4,r3,r2 → 0; ADDI r5,r3,1 → 0.
- Reset mid-operation: pulse `rst` asynchronously while one instruction is in EX and one is in WB → `rf_we`, `res_valid` and `busy` drop immediately and stay 0. The next instruction after reset retires normally.
